// File: rtl/ofmap_deaggregator.sv
// ofmap_deaggregator
// Drains finished ofmap words from the accumulation buffer read bank and
// serialises each ARRAY_WIDTH-lane word into single-element FIFO writes.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ofmap_db_empty_n    read bank still holds unread entries
//   ofmap_switch_banks  one-cycle bank-swap pulse (clears the read address)
//   ofmap_wb_ren        read strobe to buffer and controller
//   ofmap_wb_radr       read address
//   ofmap_wb_rdata      read data, valid the cycle after ofmap_wb_ren
//   ofmap_fifo_din      element presented to the output FIFO
//   ofmap_fifo_enq      enqueue strobe
//   ofmap_fifo_full_n   output FIFO can accept
//
// Build option
//   OFMAP_DEAGG_MSB_FIRST_EN  emit the highest lane first instead of lane 0.
//
// state | meaning
// IDLE  | waiting for an unread entry; issues the read
// WAIT  | read data arrives and is captured
// DRAIN | one element per cycle to the FIFO while it accepts
module ofmap_deaggregator #(
  parameter int OFMAP_WIDTH           = 32,
  parameter int ARRAY_WIDTH           = 4,
  parameter int OFMAP_BANK_ADDR_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ofmap_db_empty_n,
  input  logic                               ofmap_switch_banks,
  output logic                               ofmap_wb_ren,
  output logic [OFMAP_BANK_ADDR_WIDTH-1:0]   ofmap_wb_radr,
  input  logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0] ofmap_wb_rdata,
  output logic [OFMAP_WIDTH-1:0]             ofmap_fifo_din,
  output logic                               ofmap_fifo_enq,
  input  logic                               ofmap_fifo_full_n
);

  localparam int WORD_W = ARRAY_WIDTH * OFMAP_WIDTH;
  localparam int IDX_W  = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  // Holds the lanes not yet presented on ofmap_fifo_din; the current
  // element lives in the din register itself.
  logic [WORD_W-1:0] shreg;

  // Read strobe is combinational so the read issues in the same IDLE cycle;
  // gated by rst_n so it is low throughout reset.
  assign ofmap_wb_ren   = rst_n && (state == IDLE) && ofmap_db_empty_n && !ofmap_switch_banks;
  assign ofmap_fifo_enq = (state == DRAIN) && ofmap_fifo_full_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      shreg          <= '0;
      ofmap_fifo_din <= '0;
      ofmap_wb_radr  <= '0;
    end else begin
      if (ofmap_switch_banks)
        ofmap_wb_radr <= '0;
      else if (ofmap_wb_ren)
        ofmap_wb_radr <= ofmap_wb_radr + 1'b1;

      case (state)
        IDLE: begin
          if (ofmap_wb_ren) state <= WAIT;
        end
        WAIT: begin
`ifdef OFMAP_DEAGG_MSB_FIRST_EN
          ofmap_fifo_din <= ofmap_wb_rdata[WORD_W-1 -: OFMAP_WIDTH];
          shreg          <= ofmap_wb_rdata << OFMAP_WIDTH;
`else
          ofmap_fifo_din <= ofmap_wb_rdata[OFMAP_WIDTH-1:0];
          shreg          <= ofmap_wb_rdata >> OFMAP_WIDTH;
`endif
          idx   <= '0;
          state <= DRAIN;
        end
        DRAIN: begin
          if (ofmap_fifo_full_n) begin
`ifdef OFMAP_DEAGG_MSB_FIRST_EN
            ofmap_fifo_din <= shreg[WORD_W-1 -: OFMAP_WIDTH];
            shreg          <= shreg << OFMAP_WIDTH;
`else
            ofmap_fifo_din <= shreg[OFMAP_WIDTH-1:0];
            shreg          <= shreg >> OFMAP_WIDTH;
`endif
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
